// File: rtl/countdown_ctrl_if.sv
// Job-request handshake between a requester and countdown_ctrl.
// The requester presents load_val/auto_reload with start_valid; the controller answers with start_ready.
interface countdown_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;

  modport master (
    output start_valid,
    output load_val,
    output auto_reload,
    input  start_ready
  );

  modport slave (
    input  start_valid,
    input  load_val,
    input  auto_reload,
    output start_ready
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Sequencing controller for a down-counter: accepts a load value, counts to zero,
// and supports pause, abort and optional auto-reload.
module countdown_ctrl #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  countdown_ctrl_if.slave   s_if,
  input  logic              i_pause,
  input  logic              i_abort,
  output logic              o_busy,
  output logic [WIDTH-1:0]  o_count,
  output logic              o_tc,
  output logic              o_done,
  output logic [WRAP_W-1:0] o_wraps
);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [WIDTH-1:0]    r_count;
  logic [WIDTH-1:0]    w_count_next;
  logic [WIDTH-1:0]    r_reload;
  logic [WIDTH-1:0]    w_reload_next;
  logic                r_ar;
  logic                w_ar_next;
  logic [WRAP_W-1:0]   r_wraps;
  logic [WRAP_W-1:0]   w_wraps_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_count  <= '0;
      r_reload <= '0;
      r_ar     <= 1'b0;
      r_wraps  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_reload <= w_reload_next;
      r_ar     <= w_ar_next;
      r_wraps  <= w_wraps_next;
    end
  end

  // Within RUN the priority is abort, then pause, then counting.
  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_reload_next = r_reload;
    w_ar_next     = r_ar;
    w_wraps_next  = r_wraps;
    unique case (r_state)
      StIdle: begin
        if (s_if.start_valid) begin
          w_state_next  = StRun;
          w_count_next  = s_if.load_val;
          w_reload_next = s_if.load_val;
          w_ar_next     = s_if.auto_reload;
          w_wraps_next  = '0;
        end
      end
      StRun: begin
        if (i_abort) begin
          w_state_next = StIdle;
          w_count_next = '0;
        end else if (i_pause) begin
          w_state_next = StPaused;
        end else if (r_count != '0) begin
          w_count_next = r_count - WIDTH'(1);
        end else if (r_ar) begin
          w_count_next = r_reload;
          w_wraps_next = r_wraps + WRAP_W'(1);
        end else begin
          w_state_next = StDone;
        end
      end
      StPaused: begin
        if (i_abort) begin
          w_state_next = StIdle;
          w_count_next = '0;
        end else if (!i_pause) begin
          w_state_next = StRun;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_comb begin
    s_if.start_ready = (r_state == StIdle);
    o_busy           = (r_state != StIdle);
    o_tc             = (r_state == StRun) && (r_count == '0) && !i_pause && !i_abort;
    o_done           = (r_state == StDone);
    o_count          = r_count;
    o_wraps          = r_wraps;
  end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for the 4-bit down-counter datapath. It accepts a load value through a valid/ready handshake, then runs the count down to zero, with pause, abort and optional auto-reload. It flags each terminal count and signals completion. It sits between a requesting master (CPU/test logic) and the count register it owns, exposing the live count.

## Interface
- WIDTH, 4: width of load value and count.
- WRAP_W, 8: width of the auto-reload wrap counter.

- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_valid  input  1  requester presents a job (load_val, auto_reload).
- start_ready  output  1  controller can accept a job; high only in IDLE.
- load_val  input  WIDTH  start value; sampled on accept.
- auto_reload  input  1  sampled on accept; 1 = reload and keep running at terminal count.
- pause  input  1  level; freezes the count while high.
- abort  input  1  level; terminates the current job without done.
- busy  output  1  high in every state except IDLE.
- count  output  WIDTH  current count register.
- tc  output  1  terminal-count event taken this cycle.
- done  output  1  one-cycle completion pulse.
- wraps  output  WRAP_W  number of auto-reloads since the last accept.

## Operation
- States:
  - IDLE: start_ready=1.
  - RUN
  - PAUSED
  - DONE: done=1 for its single cycle.
- Accept: a job is accepted at the edge where start_valid && start_ready.
  - On accept: count<=load_val, reload_reg<=load_val, ar_reg<=auto_reload, wraps<=0, next state RUN.
  - abort is ignored in IDLE; a start presented alongside abort in IDLE is still accepted.
- RUN, priority abort > pause > count:
  - abort: next state IDLE, count<=0, no done, no tc.
  - pause: next state PAUSED, count holds, tc=0.
  - count!=0: count<=count-1.
  - count==0 with ar_reg=1: count<=reload_reg, wraps<=wraps+1 (wraps modulo 2^WRAP_W), stay in RUN.
  - count==0 with ar_reg=0: next state DONE, count holds at 0.
- tc = (state==RUN) && count==0 && !pause && !abort. Decoded combinationally from registered state.
- PAUSED:
  - abort: IDLE, count<=0.
  - pause low: RUN, count unchanged at that edge.
  - otherwise: hold.
- DONE: next state IDLE unconditionally. abort in DONE also goes to IDLE; done is still high for that cycle.
- start_valid while not in IDLE is not accepted; the requester must hold it until ready.
- Load of 0 is legal: RUN is entered with count 0, so tc fires in the first RUN cycle.
  - ar_reg=0: DONE follows.
  - ar_reg=1: tc fires every cycle and wraps increments every cycle.
- Arithmetic: count decrements without underflow, because the decrement is never taken at 0. wraps rolls over from 2^WRAP_W-1 to 0.

## Timing
- Reset values (cycle after reset sampled high): state IDLE, count=0, wraps=0, busy=0, tc=0, done=0, start_ready=1.
- Reset mid-job, in any state: IDLE next cycle, no done pulse, reload_reg and ar_reg cleared.
- Accept at edge k with load N, no pause/abort, ar=0:
  - count=N in cycle k+1, then N-1, and so on.
  - count=0 with tc=1 in cycle k+1+N.
  - done=1 in cycle k+2+N.
  - start_ready=1 again in cycle k+3+N.
- busy is high in cycles k+1 through k+2+N.
- Each pause cycle sampled in RUN/PAUSED adds exactly one cycle to total latency. Exiting PAUSED costs one cycle in which the count holds.
- Auto-reload period is N+1 cycles per wrap (N..0 inclusive).
- Back-to-back jobs: minimum spacing between accepts is N+3 cycles.

## Test plan
- Reset then load 3, ar=0:
  - count 3,2,1,0 in consecutive cycles after accept;
  - tc once at count 0; done one cycle later; start_ready 1 the cycle after done.
- Load 2, pause held high 3 cycles while count=1: count stays 1 for 4 cycles (3 PAUSED + 1 resume) before reaching 0; total done latency grows by 4.
- Load 1, ar=1, run 6 cycles:
  - count 1,0,1,0,1,0; tc on each 0;
  - wraps reaches 3; done never asserts; busy stays 1.
- Load 5, abort at count=3:
  - next cycle IDLE with count=0, done=0, tc=0, start_ready=1.
  - A start with load 2 held during that abort cycle is not accepted; the same request is accepted at the next edge.
- Load 0, ar=0:
  - tc in the first RUN cycle; done the next cycle; count remains 0 throughout.
- Load 4, reset asserted at count=2:
  - IDLE, count=0, wraps=0, done=0 the next cycle.
  - A new load 1 is then accepted normally and completes with done after 3 cycles.
